// File: rtl/flappy_pkg.sv
// Shared definitions for the button conditioning path: button indices,
// debounce FSM state encoding and a counter-width helper.
package flappy_pkg;

    localparam int BTN_C = 0;
    localparam int BTN_D = 1;
    localparam int BTN_U = 2;
    localparam int BTN_R = 3;
    localparam int BTN_L = 4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_PRESS = 3'd1,
        PULSE      = 3'd2,
        HELD       = 3'd3,
        WAIT_REL   = 3'd4
    } btn_state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/btn_debounce_unit.sv
// One button: two-flop synchroniser, debounce/hold FSM and repeat timer.
// Press and release are each accepted after DEBOUNCE_CYCLES stable samples; all outputs registered.
module btn_debounce_unit
    import flappy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse,
    output logic o_rpt
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
        $error("btn_debounce_unit: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end

    logic             r_s1;
    logic             r_s2;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_rpt_cnt;
    logic             r_first_done;
    logic             r_level;
    logic             r_pulse;
    logic             r_rpt;
    logic [CNT_W-1:0] w_rpt_thr;

    assign w_rpt_thr = r_first_done ? RPT_PER_LAST : RPT_DLY_LAST;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_state      <= IDLE;
            r_db_cnt     <= CNT_ZERO;
            r_rpt_cnt    <= CNT_ZERO;
            r_first_done <= 1'b0;
            r_level      <= 1'b0;
            r_pulse      <= 1'b0;
            r_rpt        <= 1'b0;
        end else begin
            r_s1    <= i_btn;
            r_s2    <= r_s1;
            r_pulse <= 1'b0;
            r_rpt   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_s2) begin
                        r_state  <= WAIT_PRESS;
                        r_db_cnt <= CNT_ONE;
                    end
                end
                WAIT_PRESS: begin
                    if (!r_s2) begin
                        r_state  <= IDLE;
                        r_db_cnt <= CNT_ZERO;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state      <= PULSE;
                        r_db_cnt     <= CNT_ZERO;
                        r_rpt_cnt    <= CNT_ZERO;
                        r_first_done <= 1'b0;
                        r_level      <= 1'b1;
                        r_pulse      <= 1'b1;
                        r_rpt        <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + CNT_ONE;
                    end
                end
                PULSE: begin
                    // The pulse cycle is the first held cycle, so the first
                    // repeat lands exactly REPEAT_DELAY after the press pulse.
                    r_state   <= HELD;
                    r_rpt_cnt <= CNT_ONE;
                end
                HELD: begin
                    if (!r_s2) begin
                        r_state  <= WAIT_REL;
                        r_db_cnt <= CNT_ONE;
                    end else if (r_rpt_cnt == w_rpt_thr) begin
                        r_rpt        <= 1'b1;
                        r_first_done <= 1'b1;
                        r_rpt_cnt    <= CNT_ZERO;
                    end else begin
                        r_rpt_cnt <= r_rpt_cnt + CNT_ONE;
                    end
                end
                WAIT_REL: begin
                    // rpt_cnt is frozen here; a bounce back to high resumes the schedule.
                    if (r_s2) begin
                        r_state  <= HELD;
                        r_db_cnt <= CNT_ZERO;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state  <= IDLE;
                        r_db_cnt <= CNT_ZERO;
                        r_level  <= 1'b0;
                    end else begin
                        r_db_cnt <= r_db_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;
    assign o_rpt   = r_rpt;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw board buttons into debounced level, press pulse and auto-repeat pulse.
// Each button is an independent btn_debounce_unit; bit order {BtnL, BtnR, BtnU, BtnD, BtnC}.
module button_conditioner
    import flappy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000,
    parameter int N_BTN           = 5
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_rpt
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_debounce_unit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_unit (
            .i_clk   (Clk),
            .i_reset (reset),
            .i_btn   (btn_in[g]),
            .o_level (btn_level[g]),
            .o_pulse (btn_pulse[g]),
            .o_rpt   (btn_rpt[g])
        );
    end

endmodule
